// File: rtl/counter_disp_pkg.sv
// counter_disp_pkg: shared state type, scan default and seven-segment codes
package counter_disp_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int SCAN_DIV_DEFAULT = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: bcd digit plus blank flag to active-low gfedcba segment code
module seg7_decoder
  import counter_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (!blank)
      case (bcd)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
  end
endmodule

// File: rtl/counter_bcd_display.sv
// counter_bcd_display: double-dabble binary to bcd converter driving a scanned 3-digit display
module counter_bcd_display
  import counter_disp_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_aclear,
  input  logic [7:0]  i_counter,
  output logic [11:0] o_bcd,
  output logic        o_valid,
  output logic        o_busy,
  output logic [6:0]  o_seg,
  output logic [2:0]  o_an
);
  state_t      state, state_nx;
  logic [7:0]  r_last;
  logic [19:0] r_shift;
  logic [11:0] bcd_adj;
  logic [2:0]  r_iter;
  logic [7:0]  r_presc;
  logic [1:0]  r_dig;
  logic [3:0]  dig_val;
  logic        dig_blank;
  logic [6:0]  seg_nx;
  logic        start;
  logic        presc_wrap;
  assign start = state == IDLE && i_counter != r_last;
  assign presc_wrap = r_presc == 8'(SCAN_DIV - 1);
  assign o_busy = state != IDLE;
  for (genvar g = 0; g < 3; g++) begin : g_adj
    assign bcd_adj[4*g +: 4] = r_shift[8+4*g +: 4] >= 4'd5 ? r_shift[8+4*g +: 4] + 4'd3 : r_shift[8+4*g +: 4];
  end
  always_ff @(posedge i_clk or negedge i_aclear)
    if (!i_aclear) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (r_iter == 3'd7 ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_aclear)
    if (!i_aclear) begin
      r_last  <= '0;
      r_shift <= '0;
      r_iter  <= '0;
      o_bcd   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= state == DONE;
      if (start) begin
        r_shift <= {12'd0, i_counter};
        r_last  <= i_counter;
        r_iter  <= '0;
      end else if (state == SHIFT) begin
        r_shift <= {bcd_adj[10:0], r_shift[7:0], 1'b0};
        r_iter  <= r_iter + 3'd1;
      end
      if (state == DONE) o_bcd <= r_shift[19:8];
    end
  assign dig_val   = r_dig == 2'd2 ? o_bcd[11:8] : r_dig == 2'd1 ? o_bcd[7:4] : o_bcd[3:0];
  assign dig_blank = r_dig == 2'd2 ? o_bcd[11:8] == 4'd0 : r_dig == 2'd1 && o_bcd[11:4] == 8'd0;
  seg7_decoder u_dec (.bcd(dig_val), .blank(dig_blank), .seg(seg_nx));
  always_ff @(posedge i_clk or negedge i_aclear)
    if (!i_aclear) begin
      r_presc <= '0;
      r_dig   <= '0;
      o_an    <= 3'b110;
      o_seg   <= SEG_0;
    end else begin
      r_presc <= presc_wrap ? 8'd0 : r_presc + 8'd1;
      if (presc_wrap) r_dig <= r_dig == 2'd2 ? 2'd0 : r_dig + 2'd1;
      o_an  <= ~(3'b001 << r_dig);
      o_seg <= seg_nx;
    end
endmodule

// File: tb/tb_counter_bcd_display.sv
// tb_counter_bcd_display: randomized and directed checks against a value-level reference model
module tb_counter_bcd_display;
  localparam int DIV = 4;
  logic        clk = 1'b0;
  logic        i_aclear = 1'b0;
  logic [7:0]  i_counter = 8'd0;
  logic [11:0] o_bcd;
  logic        o_valid;
  logic        o_busy;
  logic [6:0]  o_seg;
  logic [2:0]  o_an;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] m_val = 8'd0;
  logic [7:0] m_last = 8'd0;
  int         m_left = 0;
  int         m_k = 0;
  logic       m_valid = 1'b0;
  logic [2:0] m_an = 3'b110;
  logic [6:0] m_seg = 7'b1000000;
  counter_bcd_display #(.SCAN_DIV(DIV)) dut (
    .i_clk(clk), .i_aclear(i_aclear), .i_counter(i_counter),
    .o_bcd(o_bcd), .o_valid(o_valid), .o_busy(o_busy), .o_seg(o_seg), .o_an(o_an)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] seg_tab(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction
  function automatic logic [11:0] bcd_of(input logic [7:0] v);
    int x;
    x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction
  function automatic logic [2:0] an_of(input int d);
    return d == 0 ? 3'b110 : d == 1 ? 3'b101 : 3'b011;
  endfunction
  function automatic logic [6:0] seg_of(input int d, input logic [7:0] v);
    int x;
    x = int'(v);
    if (d == 0) return seg_tab(x % 10);
    if (d == 1) return x < 10 ? 7'b1111111 : seg_tab((x / 10) % 10);
    return x < 100 ? 7'b1111111 : seg_tab(x / 100);
  endfunction
  always @(posedge clk or negedge i_aclear)
    if (!i_aclear) begin
      m_val   <= 8'd0;
      m_last  <= 8'd0;
      m_left  <= 0;
      m_k     <= 0;
      m_valid <= 1'b0;
      m_an    <= 3'b110;
      m_seg   <= 7'b1000000;
    end else begin
      m_k     <= m_k + 1;
      m_an    <= an_of((m_k / DIV) % 3);
      m_seg   <= seg_of((m_k / DIV) % 3, m_val);
      m_valid <= m_left == 1;
      if (m_left == 1) m_val <= m_last;
      if (m_left > 0) m_left <= m_left - 1;
      else if (i_counter != m_last) begin
        m_last <= i_counter;
        m_left <= 9;
      end
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("bcd", 32'(o_bcd), 32'(bcd_of(m_val)));
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("busy", 32'(o_busy), 32'(m_left > 0));
    chk("an", 32'(o_an), 32'(m_an));
    chk("seg", 32'(o_seg), 32'(m_seg));
    chk("an_onehot", 32'($countones(~o_an)), 32'd1);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_bcd"}, 32'(o_bcd), 32'h000);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_an"}, 32'(o_an), 32'b110);
    chk({tag, "_seg"}, 32'(o_seg), 32'b1000000);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset("rst");
    i_aclear = 1'b1;
    cyc();
    i_counter = 8'd20;
    cyc();
    chk("busy_edge1", 32'(o_busy), 32'd1);
    for (int i = 2; i <= 9; i++) begin
      cyc();
      chk("no_early_valid", 32'(o_valid), 32'd0);
    end
    cyc();
    chk("bcd_20", 32'(o_bcd), 32'h020);
    chk("valid_edge10", 32'(o_valid), 32'd1);
    cyc();
    chk("valid_one_cycle", 32'(o_valid), 32'd0);
    repeat (6 * DIV) cyc();
    i_counter = 8'd255;
    repeat (10) cyc();
    chk("bcd_255", 32'(o_bcd), 32'h255);
    i_counter = 8'd0;
    repeat (10) cyc();
    chk("bcd_0", 32'(o_bcd), 32'h000);
    for (int v = 20; v <= 40; v++) begin
      i_counter = 8'(v);
      cyc();
    end
    repeat (30) cyc();
    chk("bcd_40", 32'(o_bcd), 32'h040);
    i_counter = 8'd7;
    repeat (10) cyc();
    chk("bcd_7", 32'(o_bcd), 32'h007);
    repeat (4 * DIV) cyc();
    i_counter = 8'd105;
    repeat (10) cyc();
    chk("bcd_105", 32'(o_bcd), 32'h105);
    repeat (4 * DIV) cyc();
    i_counter = 8'd200;
    repeat (4) cyc();
    #2 i_aclear = 1'b0;
    #1 chk_reset("midrst");
    #9 i_aclear = 1'b1;
    repeat (10) cyc();
    chk("bcd_200", 32'(o_bcd), 32'h200);
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) i_counter = 8'($urandom_range(0, 255));
      cyc();
    end
    repeat (12) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/counter_bcd_display.md
COUNTER_BCD_DISPLAY -- requirements
Module: counter_bcd_display

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each display digit stays enabled; legal range 1..255.
REQ-002 i_clk  input  1  system clock; all state updates on its rising edge.
REQ-003 i_aclear  input  1  asynchronous, active-low reset; one clock, no other reset.
REQ-004 i_counter  input  8  unsigned binary value from the upstream counter's o_counter, synchronous to i_clk.
REQ-005 o_bcd  output  12  last converted value as BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-006 o_valid  output  1  one-cycle pulse when o_bcd updates.
REQ-007 o_busy  output  1  high while a conversion is in progress.
REQ-008 o_seg  output  7  active-low segments, bit order gfedcba, for the enabled digit.
REQ-009 o_an  output  3  active-low one-hot digit enable: [0] ones, [1] tens, [2] hundreds.

Function
REQ-010 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-011 IDLE: on an edge where i_counter != r_last, capture i_counter into the shift register and r_last, clear the iteration count, and go to SHIFT; otherwise stay in IDLE.
REQ-012 SHIFT: each edge, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one; after exactly 8 SHIFT edges go to DONE.
REQ-013 DONE: load o_bcd from the BCD register, pulse o_valid for one cycle, and return to IDLE on the same edge.
REQ-014 Latency: o_bcd and o_valid are updated on the 10th rising edge, counting the capture edge as edge 1.
REQ-015 o_busy is high in SHIFT and DONE and low in IDLE.
REQ-016 While busy, i_counter changes are ignored; the first IDLE edge after completion compares against r_last, so the final settled value is always converted.
REQ-017 Full range 0..255 is converted exactly; the hundreds nibble is never above 2.
REQ-018 Scan: a prescaler counts 0..SCAN_DIV-1; on wrap, the digit index advances 0 -> 1 -> 2 -> 0.
REQ-019 Exactly one o_an bit is low at any time outside reset.
REQ-020 o_seg shows the digit of o_bcd selected by the digit index, not the in-flight conversion value.
REQ-021 Leading-zero blanking: hundreds is blank (7'b1111111) when 0; tens is blank when both hundreds and tens are 0; ones is always shown.
REQ-022 Segment codes, gfedcba active-low:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-023 o_seg and o_an are registered outputs.

Reset
REQ-024 While i_aclear = 0, regardless of i_clk:
- state IDLE; r_last, shift register, iteration count and prescaler = 0
- o_bcd = 12'h000; o_valid = 0; o_busy = 0
- digit index = 0; o_an = 3'b110; o_seg = 7'b1000000
REQ-025 Reset asserted mid-conversion aborts it and leaves o_bcd = 0; after release, a non-zero i_counter is converted per REQ-011.
REQ-026 Release is synchronous in effect: the first active edge after i_aclear rises performs normal IDLE evaluation.

Structure
REQ-027 Package counter_disp_pkg holds the state enum, the SCAN_DIV default, the blank code and the 10 segment constants.
REQ-028 Sub-module seg7_decoder: combinational 4-bit BCD plus blank flag -> 7-bit segment code; instantiated once.

Verification
REQ-029 Reset, then i_counter = 20: o_busy high from edge 1; on edge 10 o_bcd = 12'h020 and o_valid pulses once.
REQ-030 i_counter = 255 -> o_bcd = 12'h255; i_counter = 0 after that -> o_bcd = 12'h000, each with 10-edge latency.
REQ-031 i_counter increments every cycle from 20 to 40, then holds: intermediate values are skipped, no o_valid pulse while busy, final o_bcd = 12'h040.
REQ-032 SCAN_DIV = 4, o_bcd = 12'h020: repeating sequence, 4 cycles each:
- o_an = 110 with o_seg = 1000000
- o_an = 101 with o_seg = 0100100
- o_an = 011 with o_seg = 1111111
REQ-033 i_aclear pulsed low for 10 ns during SHIFT of a conversion of 200: outputs return to reset values immediately; after release, conversion of 200 completes with o_bcd = 12'h200.
REQ-034 o_bcd = 12'h007 -> hundreds and tens blank, ones = 1111000; o_bcd = 12'h105 -> tens shows 1000000, not blanked.
